// File: rtl/gelato_ifetch_if.sv
// Bus bundle between fetch scheduler, instruction memory and decode for gelato_ifetch.
// Latency: none (wires only).
// Backpressure: valid/ready on request and decode sides; memory responses carry no backpressure.
// Groups: request (pc_valid/pc_ready/pc/warp_num/split_table_num), imem request/response,
// decode (dec_valid/dec_ready/dec_*). dec_misalign exists only with GELATO_IFETCH_MISALIGN_CHECK_EN.
// Modport slave is the fetch stage's view; master is the surrounding environment's view.
interface gelato_ifetch_if #(
    parameter int PC_WIDTH        = 32,
    parameter int INST_WIDTH      = 32,
    parameter int WARP_NUM_WIDTH  = 5,
    parameter int SPLIT_NUM_WIDTH = 4
) ();
    logic                       pc_valid;
    logic                       pc_ready;
    logic [PC_WIDTH-1:0]        pc;
    logic [WARP_NUM_WIDTH-1:0]  warp_num;
    logic [SPLIT_NUM_WIDTH-1:0] split_table_num;

    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [PC_WIDTH-1:0]        imem_req_addr;
    logic                       imem_rsp_valid;
    logic [INST_WIDTH-1:0]      imem_rsp_data;

    logic                       dec_valid;
    logic                       dec_ready;
    logic [INST_WIDTH-1:0]      dec_inst;
    logic [PC_WIDTH-1:0]        dec_pc;
    logic [WARP_NUM_WIDTH-1:0]  dec_warp_num;
    logic [SPLIT_NUM_WIDTH-1:0] dec_split_table_num;
`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
    logic                       dec_misalign;

    modport slave (
        input  pc_valid, pc, warp_num, split_table_num,
        output pc_ready,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_inst, dec_pc, dec_warp_num, dec_split_table_num, dec_misalign,
        input  dec_ready
    );

    modport master (
        output pc_valid, pc, warp_num, split_table_num,
        input  pc_ready,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_inst, dec_pc, dec_warp_num, dec_split_table_num, dec_misalign,
        output dec_ready
    );
`else
    modport slave (
        input  pc_valid, pc, warp_num, split_table_num,
        output pc_ready,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_valid, dec_inst, dec_pc, dec_warp_num, dec_split_table_num,
        input  dec_ready
    );

    modport master (
        output pc_valid, pc, warp_num, split_table_num,
        input  pc_ready,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_valid, dec_inst, dec_pc, dec_warp_num, dec_split_table_num,
        output dec_ready
    );
`endif
endinterface

// File: rtl/gelato_ifetch.sv
// Instruction fetch stage: issues imem reads for scheduled pcs, queues up to DEPTH in-order entries.
// Latency: request accepted in cycle N, response in M>=N+1, instruction offered to decode in M+1.
// Backpressure: pc_ready low when queue full, rdy low or imem not ready; decode stalls hold dec_*.
// Ports: clk, rst_n (async active-low), rdy (global enable: freezes accept and pop, not capture),
//        bus (gelato_ifetch_if.slave: scheduler request, imem request/response, decode output).
// Option: GELATO_IFETCH_MISALIGN_CHECK_EN turns pcs with pc[1:0]!=0 into locally completed
//         entries flagged via dec_misalign instead of memory reads.
module gelato_ifetch #(
    parameter int PC_WIDTH        = 32,
    parameter int INST_WIDTH      = 32,
    parameter int WARP_NUM_WIDTH  = 5,
    parameter int SPLIT_NUM_WIDTH = 4,
    parameter int DEPTH           = 4
) (
    input logic           clk,
    input logic           rst_n,
    input logic           rdy,
    gelato_ifetch_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Entry storage
    logic [PC_WIDTH-1:0]        ent_pc    [DEPTH];
    logic [WARP_NUM_WIDTH-1:0]  ent_warp  [DEPTH];
    logic [SPLIT_NUM_WIDTH-1:0] ent_split [DEPTH];
    logic [INST_WIDTH-1:0]      ent_inst  [DEPTH];
    logic [DEPTH-1:0]           filled;
`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
    logic [DEPTH-1:0]           ent_mis;
`endif

    ptr_t head;   // next entry handed to decode
    ptr_t tail;   // next entry allocated
    ptr_t fill;   // next entry to receive a memory response
    cnt_t count;  // allocated entries
    // Reads issued but not yet answered. Kept separately because fill==tail is
    // ambiguous when every entry of a full queue is still outstanding.
    cnt_t pend;

    logic full;
    logic req_ok;
    logic mis;
    logic acc;
    logic acc_mem;
    logic rsp_take;
    logic pop;

    assign full   = (count == cnt_t'(DEPTH));
    // Gated by rst_n so the combinational handshake stays quiet while in reset.
    assign req_ok = rst_n && rdy && !full;

`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
    assign mis                = (bus.pc[1:0] != 2'b00);
    // A misaligned pc completes locally, so it must not overtake reads still in flight.
    assign bus.pc_ready       = req_ok && (mis ? (pend == '0) : bus.imem_req_ready);
    assign bus.dec_misalign   = ent_mis[head];
`else
    assign mis                = 1'b0;
    assign bus.pc_ready       = req_ok && bus.imem_req_ready;
`endif
    assign bus.imem_req_valid = bus.pc_valid && req_ok && !mis;
    assign bus.imem_req_addr  = bus.pc;

    assign acc      = bus.pc_valid && bus.pc_ready;
    assign acc_mem  = acc && !mis;
    // Responses with nothing in flight (e.g. for reads issued before a reset) are dropped.
    assign rsp_take = bus.imem_rsp_valid && (pend != '0);
    assign pop      = filled[head] && bus.dec_ready && rdy;

    assign bus.dec_valid           = filled[head];
    assign bus.dec_inst            = ent_inst[head];
    assign bus.dec_pc              = ent_pc[head];
    assign bus.dec_warp_num        = ent_warp[head];
    assign bus.dec_split_table_num = ent_split[head];

    // Index collisions cannot occur: accept never targets head while it is filled
    // (tail==head only when empty, and full blocks accept), and the response slot is
    // always unfilled while head is filled whenever a pop happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            fill   <= '0;
            count  <= '0;
            pend   <= '0;
            filled <= '0;
`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
            ent_mis <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]    <= '0;
                ent_warp[i]  <= '0;
                ent_split[i] <= '0;
                ent_inst[i]  <= '0;
            end
        end else begin
            if (acc) begin
                ent_pc[tail]    <= bus.pc;
                ent_warp[tail]  <= bus.warp_num;
                ent_split[tail] <= bus.split_table_num;
                ent_inst[tail]  <= '0;
                filled[tail]    <= mis;
`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
                ent_mis[tail]   <= mis;
                // No reads are in flight here, so fill sits on tail and moves with it.
                if (mis) fill <= fill + 1'b1;
`endif
                tail <= tail + 1'b1;
            end

            if (rsp_take) begin
                ent_inst[fill] <= bus.imem_rsp_data;
                filled[fill]   <= 1'b1;
                fill           <= fill + 1'b1;
            end

            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + 1'b1;
            end

            count <= count + cnt_t'(acc) - cnt_t'(pop);
            pend  <= pend + cnt_t'(acc_mem) - cnt_t'(rsp_take);
        end
    end
endmodule

// File: tb/tb_gelato_ifetch.sv
module tb_gelato_ifetch;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    always #5 clk = ~clk;

    gelato_ifetch_if bus ();

    gelato_ifetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  warp;
        logic [3:0]  split;
        logic        mis;
    } ent_t;

    ent_t req_q[$];   // accepted requests awaiting their memory response
    ent_t exp_q[$];   // completed entries in the order decode must see them

    int n_assert = 0;
    int n_fail   = 0;
    int pops     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled on the falling edge, where inputs and outputs are stable.
    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            if (bus.imem_rsp_valid && req_q.size() > 0) begin
                e = req_q.pop_front();
                e.inst = bus.imem_rsp_data;
                exp_q.push_back(e);
            end
            if (bus.pc_valid && bus.pc_ready) begin
                e = '{inst: 32'h0, pc: bus.pc, warp: bus.warp_num,
                      split: bus.split_table_num, mis: 1'b0};
`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
                if (bus.pc[1:0] != 2'b00) begin
                    e.mis = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    check("req_addr", bus.imem_req_addr, bus.pc);
                    req_q.push_back(e);
                end
`else
                check("req_addr", bus.imem_req_addr, bus.pc);
                req_q.push_back(e);
`endif
            end
            if (bus.dec_valid && bus.dec_ready && rdy) begin
                pops++;
                check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_inst",  bus.dec_inst, e.inst);
                    check("sb_pc",    bus.dec_pc, e.pc);
                    check("sb_warp",  bus.dec_warp_num, e.warp);
                    check("sb_split", bus.dec_split_table_num, e.split);
`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
                    check("sb_mis",   bus.dec_misalign, e.mis);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 1'b0;
        rdy   = 1'b1;
        bus.pc_valid        = 1'b1;
        bus.pc              = 32'h40;
        bus.warp_num        = '0;
        bus.split_table_num = '0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.dec_ready       = 1'b0;
        #3;
        check("rst_pc_ready",  bus.pc_ready, 0);
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_dec_valid", bus.dec_valid, 0);
        check("rst_dec_inst",  bus.dec_inst, 0);
        check("rst_dec_pc",    bus.dec_pc, 0);
        bus.pc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Single fetch
        bus.pc = 32'h100; bus.warp_num = 5'd3; bus.split_table_num = 4'd1; bus.pc_valid = 1'b1;
        #1;
        check("t1_pc_ready",  bus.pc_ready, 1);
        check("t1_req_valid", bus.imem_req_valid, 1);
        check("t1_req_addr",  bus.imem_req_addr, 32'h100);
        step();
        bus.pc_valid = 1'b0;
        step();
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEADBEEF;
        #1;
        check("t1_valid_early", bus.dec_valid, 0);
        step();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("t1_dec_valid", bus.dec_valid, 1);
        check("t1_dec_inst",  bus.dec_inst, 32'hDEADBEEF);
        check("t1_dec_pc",    bus.dec_pc, 32'h100);
        check("t1_dec_warp",  bus.dec_warp_num, 3);
        check("t1_dec_split", bus.dec_split_table_num, 1);
        step();
        check("t1_hold_valid", bus.dec_valid, 1);
        check("t1_hold_inst",  bus.dec_inst, 32'hDEADBEEF);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        #1;
        check("t1_pops",        pops, 1);
        check("t1_valid_after", bus.dec_valid, 0);

        // Fill the queue with decode stalled
        for (int i = 0; i < 4; i++) begin
            bus.pc = 32'(i * 4); bus.warp_num = 5'(i); bus.split_table_num = 4'(i);
            bus.pc_valid = 1'b1;
            #1;
            check("t2_pc_ready", bus.pc_ready, 1);
            step();
        end
        bus.pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hA000_0000 + 32'(i);
            step();
        end
        bus.imem_rsp_valid = 1'b0;
        bus.pc = 32'h10; bus.warp_num = 5'd9; bus.split_table_num = 4'd9; bus.pc_valid = 1'b1;
        #1;
        check("t2_full_ready", bus.pc_ready, 0);
        step();
        check("t2_full_hold", bus.pc_ready, 0);
        p0 = pops;
        bus.dec_ready = 1'b1;
        #1;
        check("t2_full_popping", bus.pc_ready, 0);
        step();
        check("t2_pop1", pops, p0 + 1);
        check("t2_ready_back", bus.pc_ready, 1);
        step();
        bus.pc_valid = 1'b0;
        check("t2_pop2", pops, p0 + 2);
        step();
        check("t2_pop3", pops, p0 + 3);
        step();
        check("t2_pop4", pops, p0 + 4);
        #1;
        check("t2_drained_valid", bus.dec_valid, 0);
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBBBB_0010;
        step();
        bus.imem_rsp_valid = 1'b0;
        step();
        check("t2_pop5", pops, p0 + 5);
        bus.dec_ready = 1'b0;

        // Memory backpressure
        bus.imem_req_ready = 1'b0;
        bus.pc = 32'h80; bus.pc_valid = 1'b1;
        #1;
        check("t3_pc_ready",  bus.pc_ready, 0);
        check("t3_req_valid", bus.imem_req_valid, 1);
        step();
        step();
        check("t3_count",     dut.count, 0);
        check("t3_dec_valid", bus.dec_valid, 0);
        bus.pc_valid = 1'b0;
        bus.imem_req_ready = 1'b1;

        // Global enable low while a response arrives
        bus.pc = 32'h200; bus.warp_num = 5'd7; bus.split_table_num = 4'd2; bus.pc_valid = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        rdy = 1'b0;
        bus.dec_ready = 1'b1;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1234_5678;
        step();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("t4_captured", bus.dec_valid, 1);
        check("t4_inst",     bus.dec_inst, 32'h1234_5678);
        p0 = pops;
        bus.pc = 32'h204; bus.pc_valid = 1'b1;
        #1;
        check("t4_pc_ready_frozen", bus.pc_ready, 0);
        step();
        bus.pc_valid = 1'b0;
        check("t4_no_pop", pops, p0);
        rdy = 1'b1;
        step();
        check("t4_pop", pops, p0 + 1);
        bus.dec_ready = 1'b0;

        // Reset with reads in flight
        bus.pc = 32'h300; bus.pc_valid = 1'b1;
        step();
        bus.pc = 32'h304;
        step();
        bus.pc_valid = 1'b0;
        check("t5_count_before", dut.count, 2);
        rst_n = 1'b0;
        req_q.delete();
        exp_q.delete();
        #1;
        check("t5_rst_count",    dut.count, 0);
        check("t5_rst_valid",    bus.dec_valid, 0);
        check("t5_rst_pc_ready", bus.pc_ready, 0);
        step();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h55;
        step();
        bus.imem_rsp_data = 32'h66;
        step();
        bus.imem_rsp_valid = 1'b0;
        step();
        check("t5_valid_after", bus.dec_valid, 0);
        check("t5_count_after", dut.count, 0);

`ifdef GELATO_IFETCH_MISALIGN_CHECK_EN
        // Misaligned pc on an empty queue
        bus.imem_req_ready = 1'b0;
        bus.pc = 32'h102; bus.warp_num = 5'd1; bus.split_table_num = 4'd2; bus.pc_valid = 1'b1;
        #1;
        check("t6_req_valid", bus.imem_req_valid, 0);
        check("t6_pc_ready",  bus.pc_ready, 1);
        step();
        bus.pc_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        check("t6_dec_valid", bus.dec_valid, 1);
        check("t6_misalign",  bus.dec_misalign, 1);
        check("t6_inst",      bus.dec_inst, 0);
        check("t6_pc",        bus.dec_pc, 32'h102);
        p0 = pops;
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        check("t6_pop", pops, p0 + 1);
        // Misaligned pc waits for an outstanding read
        bus.pc = 32'h300; bus.pc_valid = 1'b1;
        step();
        bus.pc = 32'h102;
        #1;
        check("t6_wait_ready", bus.pc_ready, 0);
        step();
        check("t6_wait_ready2", bus.pc_ready, 0);
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h77;
        #1;
        check("t6_wait_ready3", bus.pc_ready, 0);
        step();
        bus.imem_rsp_valid = 1'b0;
        #1;
        check("t6_ready_after_rsp", bus.pc_ready, 1);
        step();
        bus.pc_valid = 1'b0;
        p0 = pops;
        bus.dec_ready = 1'b1;
        step();
        step();
        bus.dec_ready = 1'b0;
        check("t6_pops", pops, p0 + 2);
`endif

        step();
        check("exp_drained", 64'(exp_q.size()), 0);
        check("req_drained", 64'(req_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
